// File: rtl/gen_sched_pkg.sv
// Shared types and constants for the fibonacci/timer write-port scheduler.
// Optional per-generator word counters: GEN_SCHED_WORD_CNT_EN.
package gen_sched_pkg;

  localparam logic [5:0] LED_IDLE  = 6'd0;
  localparam logic [5:0] LED_GNT_F = 6'd1;
  localparam logic [5:0] LED_GNT_T = 6'd2;
  localparam logic [5:0] LED_GAP   = 6'd4;
  localparam logic [5:0] LED_HOLD  = 6'd8;
  localparam logic [5:0] LED_DRAIN = 6'd16;

  // State encoding doubles as the LED one-hot pattern.
  typedef enum logic [5:0] {
    S_IDLE  = LED_IDLE,
    S_GNT_F = LED_GNT_F,
    S_GNT_T = LED_GNT_T,
    S_GAP   = LED_GAP,
    S_HOLD  = LED_HOLD,
    S_DRAIN = LED_DRAIN
  } state_t;

  localparam logic [1:0] GM_NONE = 2'b00;
  localparam logic [1:0] GM_TIM  = 2'b01;
  localparam logic [1:0] GM_FIB  = 2'b10;
  localparam logic [1:0] GM_BOTH = 2'b11;

  localparam logic OWN_F = 1'b0;
  localparam logic OWN_T = 1'b1;

  function automatic logic [1:0] gm_code(input logic af,
                                         input logic at);
    return {af, at};
  endfunction

endpackage

// File: rtl/quota_counter.sv
// Burst quota counter: counts accepted words, wraps at BURST.
// hit flags that the current word would be the last of the burst.
module quota_counter #(
  parameter int BURST = 4,
  parameter int W     = $clog2(BURST) + 1
) (
  input  logic clock,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_hit
);

  logic [W-1:0] r_q;
  logic         w_last;

  assign w_last = (r_q == W'(BURST - 1));
  assign o_hit  = w_last;

  always_ff @(posedge clock) begin
    if (reset || i_clr) begin
      r_q <= '0;
    end else if (i_inc) begin
      r_q <= w_last ? '0 : r_q + 1'b1;
    end
  end

endmodule

// File: rtl/gen_scheduler.sv
// Round-robin owner of the wrapper write port for fib and timer generators.
// Optional word counters cnt_f/cnt_t: GEN_SCHED_WORD_CNT_EN.
module gen_scheduler
  import gen_sched_pkg::*;
#(
  parameter int BURST = 4,
  parameter int DW    = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start_f,
  input  logic          start_t,
  input  logic          stop_f_t,
  input  logic          buffer_full,
  input  logic          buffer_empty,
  input  logic          data_2_valid,
  input  logic          f_valid,
  input  logic [DW-1:0] f_out,
  input  logic          t_valid,
  input  logic [DW-1:0] t_out,
  output logic          f_en,
  output logic          t_en,
  output logic          data_1_en,
  output logic [DW-1:0] data_1,
  output logic [1:0]    gen_mod,
`ifdef GEN_SCHED_WORD_CNT_EN
  output logic [15:0]   cnt_f,
  output logic [15:0]   cnt_t,
`endif
  output logic [5:0]    LED
);

  state_t        r_state;
  logic          r_own;
  logic          r_act_f;
  logic          r_act_t;
  logic [1:0]    r_gm;
  logic          r_d1_en;
  logic [DW-1:0] r_d1;

  logic w_acc_f;
  logic w_acc_t;
  logic w_acc;
  logic w_gnt;
  logic w_other;
  logic w_hit;
  logic w_last;
  logic w_rot;
  logic w_clr;
  logic w_done;

  assign w_acc_f = f_valid & (r_own == OWN_F);
  assign w_acc_t = t_valid & (r_own == OWN_T);
  assign w_acc   = w_acc_f | w_acc_t;
  assign w_gnt   = (r_state == S_GNT_F) | (r_state == S_GNT_T);
  assign w_other = (r_own == OWN_F) ? r_act_t : r_act_f;
  assign w_last  = w_acc & w_hit & w_other;
  assign w_done  = buffer_empty & ~data_2_valid;
  assign w_clr   = (r_state == S_IDLE) | (r_state == S_GAP) |
                   (r_state == S_DRAIN);

  // Drop enable on the burst's last word so no extra word is issued.
  assign w_rot = w_gnt & ~stop_f_t & ~buffer_full & w_last;

  assign f_en      = (r_state == S_GNT_F) & ~buffer_full & ~w_rot;
  assign t_en      = (r_state == S_GNT_T) & ~buffer_full & ~w_rot;
  assign data_1_en = r_d1_en;
  assign data_1    = r_d1;
  assign gen_mod   = r_gm;
  assign LED       = 6'(r_state);

  quota_counter #(
    .BURST(BURST)
  ) u_quota (
    .clock(clock),
    .reset(reset),
    .i_inc(w_acc),
    .i_clr(w_clr),
    .o_hit(w_hit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_own   <= OWN_F;
      r_act_f <= 1'b0;
      r_act_t <= 1'b0;
      r_gm    <= GM_NONE;
    end else begin
      if (stop_f_t) begin
        r_act_f <= 1'b0;
        r_act_t <= 1'b0;
      end else begin
        if (start_f) r_act_f <= 1'b1;
        if (start_t) r_act_t <= 1'b1;
      end
      if (r_state != S_DRAIN)
        r_gm <= gm_code(r_act_f, r_act_t);
      unique case (r_state)
        S_IDLE: begin
          if (r_act_f) begin
            r_state <= S_GNT_F;
            r_own   <= OWN_F;
          end else if (r_act_t) begin
            r_state <= S_GNT_T;
            r_own   <= OWN_T;
          end
        end
        S_GNT_F, S_GNT_T: begin
          if (stop_f_t)         r_state <= S_DRAIN;
          else if (buffer_full) r_state <= S_HOLD;
          else if (w_last)      r_state <= S_GAP;
        end
        S_GAP: begin
          if (r_own == OWN_F) begin
            r_state <= S_GNT_T;
            r_own   <= OWN_T;
          end else begin
            r_state <= S_GNT_F;
            r_own   <= OWN_F;
          end
        end
        S_HOLD: begin
          if (stop_f_t)
            r_state <= S_DRAIN;
          else if (!buffer_full)
            r_state <= (r_own == OWN_T) ? S_GNT_T : S_GNT_F;
        end
        S_DRAIN: begin
          if (w_done) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_d1_en <= 1'b0;
      r_d1    <= '0;
    end else begin
      r_d1_en <= w_acc;
      if (w_acc) r_d1 <= (r_own == OWN_T) ? t_out : f_out;
    end
  end

`ifdef GEN_SCHED_WORD_CNT_EN
  logic [15:0] r_cnt_f;
  logic [15:0] r_cnt_t;
  logic        w_to_idle;

  assign w_to_idle = (r_state == S_DRAIN) & w_done;
  assign cnt_f     = r_cnt_f;
  assign cnt_t     = r_cnt_t;

  always_ff @(posedge clock) begin
    if (reset || w_to_idle) begin
      r_cnt_f <= '0;
      r_cnt_t <= '0;
    end else begin
      if (w_acc_f) r_cnt_f <= r_cnt_f + 16'd1;
      if (w_acc_t) r_cnt_t <= r_cnt_t + 16'd1;
    end
  end
`endif

endmodule
